// File: rtl/pm_loader_pkg.sv
// Shared types for the picoMIPS program-memory loader: FSM state encoding and byte-count helper.
// Pure declarations; no timing or flow control of its own.
package pm_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_DATA,
        ST_WRITE,
        ST_CHECK,
        ST_RELEASE,
        ST_ERROR
    } state_t;

    function automatic int bytes_per_instr(input int isize);
        return (isize + 7) / 8;
    endfunction

endpackage

// File: rtl/pm_loader_if.sv
// Loader-facing bundle: byte stream in, program-memory write port and core control out.
// No logic; master is the host/byte source side, slave is the loader.
interface pm_loader_if #(
    parameter int Psize = 5,
    parameter int Isize = 24
);
    logic             start;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             wr_en;
    logic [Psize-1:0] wr_addr;
    logic [Isize-1:0] wr_data;
    logic             cpu_hold;
    logic             cpu_nReset;
    logic             done;
    logic             err;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data, cpu_hold, cpu_nReset, done, err
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data, cpu_hold, cpu_nReset, done, err
    );
endinterface

// File: rtl/pm_loader_instr_assembler.sv
// Shifts bytes MSB-first into a B-byte word; o_full flags that the next load completes it.
// Word is registered, updates on the edge a byte loads; no backpressure (loads on strobe).
module instr_assembler
    import pm_loader_pkg::*;
#(
    parameter int Isize = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [7:0]       i_byte,
    output logic [Isize-1:0] o_word,
    output logic             o_full
);
    localparam int B  = bytes_per_instr(Isize);
    localparam int CW = (B > 1) ? $clog2(B) : 1;

    logic [8*B-1:0] r_sh;
    logic [8*B-1:0] w_sh_nxt;
    logic [CW-1:0]  r_cnt;

    generate
        if (B == 1) begin : g_single
            assign w_sh_nxt = i_byte;
        end else begin : g_multi
            assign w_sh_nxt = {r_sh[8*B-9:0], i_byte};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_sh  <= w_sh_nxt;
            r_cnt <= o_full ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_full = (r_cnt == CW'(B - 1));
    // Excess high bits of the first byte fall off here.
    assign o_word = r_sh[Isize-1:0];

endmodule

// File: rtl/pm_loader.sv
// picoMIPS program loader: count byte then N instructions of B bytes each, holds core in reset meanwhile.
// Write strobe one cycle after the last byte of a word; stalls indefinitely on in_valid gaps. Option: PM_LOADER_CHECKSUM_EN.
module pm_loader
    import pm_loader_pkg::*;
#(
    parameter int Psize = 5,
    parameter int Isize = 24
) (
    input  logic        clk,
    input  logic        nReset,
    pm_loader_if.slave  bus
);
    localparam int MAXN = 1 << Psize;

    state_t           r_state;
    logic [Psize:0]   r_addr;
    logic [Psize:0]   r_n;
    logic             r_wr_en;
    logic             r_hold;
    logic             r_nres;
    logic             r_done;
    logic             r_err;

    logic             w_ready;
    logic             w_acc;
    logic             w_full;
    logic             w_count_bad;
    logic [Psize:0]   w_addr_nxt;
    logic [Psize:0]   w_n_in;
    logic [Isize-1:0] w_word;

    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            ST_COUNT, ST_DATA: w_ready = 1'b1;
`ifdef PM_LOADER_CHECKSUM_EN
            ST_CHECK:          w_ready = 1'b1;
`endif
            default:           w_ready = 1'b0;
        endcase
    end

    assign w_acc       = bus.in_valid & w_ready;
    assign w_count_bad = (bus.in_data == 8'd0) || (int'(bus.in_data) > MAXN);
    assign w_n_in      = (Psize+1)'(bus.in_data);
    assign w_addr_nxt  = r_addr + 1'b1;

    instr_assembler #(.Isize(Isize)) u_asm (
        .clk    (clk),
        .rst_n  (nReset),
        .i_clr  ((r_state == ST_COUNT) && w_acc),
        .i_load ((r_state == ST_DATA) && w_acc),
        .i_byte (bus.in_data),
        .o_word (w_word),
        .o_full (w_full)
    );

`ifdef PM_LOADER_CHECKSUM_EN
    logic [7:0] r_xor;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_xor <= '0;
        end else if ((r_state == ST_COUNT) && w_acc) begin
            r_xor <= '0;
        end else if ((r_state == ST_DATA) && w_acc) begin
            r_xor <= r_xor ^ bus.in_data;
        end
    end
`endif

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_n     <= '0;
            r_wr_en <= 1'b0;
            r_hold  <= 1'b0;
            r_nres  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state <= ST_COUNT;
                        r_hold  <= 1'b1;
                        r_nres  <= 1'b0;
                    end
                end
                ST_COUNT: begin
                    if (w_acc) begin
                        if (w_count_bad) begin
                            r_state <= ST_ERROR;
                            r_err   <= 1'b1;
                        end else begin
                            r_n     <= w_n_in;
                            r_addr  <= '0;
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_acc && w_full) begin
                        r_state <= ST_WRITE;
                        r_wr_en <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    r_addr <= w_addr_nxt;
                    if (w_addr_nxt == r_n) begin
`ifdef PM_LOADER_CHECKSUM_EN
                        r_state <= ST_CHECK;
`else
                        r_state <= ST_RELEASE;
                        r_done  <= 1'b1;
`endif
                    end else begin
                        r_state <= ST_DATA;
                    end
                end
`ifdef PM_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (w_acc) begin
                        if (bus.in_data == r_xor) begin
                            r_state <= ST_RELEASE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_ERROR;
                            r_err   <= 1'b1;
                        end
                    end
                end
`endif
                // Core leaves reset on the same edge the FSM returns to idle.
                ST_RELEASE: begin
                    r_state <= ST_IDLE;
                    r_hold  <= 1'b0;
                    r_nres  <= 1'b1;
                end
                ST_ERROR: begin
                    if (bus.start) begin
                        r_state <= ST_COUNT;
                        r_err   <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = w_ready;
    assign bus.wr_en      = r_wr_en;
    assign bus.wr_addr    = r_addr[Psize-1:0];
    assign bus.wr_data    = w_word;
    assign bus.cpu_hold   = r_hold;
    assign bus.cpu_nReset = r_nres;
    assign bus.done       = r_done;
    assign bus.err        = r_err;

endmodule

// File: tb/tb_pm_loader.sv
// Randomised scoreboard bench for pm_loader (Psize=5, Isize=24); also covers PM_LOADER_CHECKSUM_EN builds.
module tb_pm_loader;
    localparam int PS   = 5;
    localparam int IS   = 24;
    localparam int B    = (IS + 7) / 8;
    localparam int MAXN = 1 << PS;

    logic clk    = 1'b0;
    logic nReset = 1'b1;

    pm_loader_if #(.Psize(PS), .Isize(IS)) bus ();

    pm_loader #(.Psize(PS), .Isize(IS)) dut (
        .clk    (clk),
        .nReset (nReset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int      addr;
        longint  data;
    } wr_t;

    wr_t  exp_q[$];
    int   n_chk     = 0;
    int   n_fail    = 0;
    int   done_cnt  = 0;
    int   wr_cnt    = 0;
    logic prev_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected writes and watches the done/release relationship.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            wr_cnt++;
            chk("write_was_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 64'(bus.wr_addr), 64'(e.addr));
                chk("wr_data", 64'(bus.wr_data), 64'(e.data));
            end
        end
        if (bus.done === 1'b1) begin
            done_cnt++;
            chk("core_held_during_done", {bus.cpu_hold, bus.cpu_nReset}, 2'b10);
        end
        if (prev_done === 1'b1)
            chk("core_released_after_done", {bus.cpu_hold, bus.cpu_nReset}, 2'b01);
        prev_done = bus.done;
    end

    // Reference: N words, each the big-endian concatenation of B bytes, truncated to IS bits.
    task automatic model_push(input byte unsigned d[$], input int n);
        for (int i = 0; i < n; i++) begin
            wr_t e;
            longint w;
            w = 0;
            for (int j = 0; j < B; j++)
                w = (w * 256) + longint'(d[i*B + j]);
            e.addr = i;
            e.data = w % (longint'(1) << IS);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_byte(input byte unsigned b, input int maxgap);
        int g;
        int n;
        g = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
        repeat (g) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk("in_ready_timeout", 64'(n), 64'd0);
        end else begin
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    // cks_bad only matters when the checksum byte is part of the protocol.
    task automatic run_load(input int n, input byte unsigned d[$], input int maxgap,
                            input bit noise, input bit cks_bad);
        bit ok;
        bit exp_done;
        int d0;
        ok = (n >= 1) && (n <= MAXN);
        d0 = done_cnt;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("ready_after_start", 64'(bus.in_ready), 64'd1);
        chk("err_clear_after_start", 64'(bus.err), 64'd0);
        chk("core_held_on_start", {bus.cpu_hold, bus.cpu_nReset}, 2'b10);
        send_byte(8'(n), maxgap);
        if (!ok) begin
            repeat (4) @(negedge clk);
            chk("bad_count_err", 64'(bus.err), 64'd1);
            chk("bad_count_hold", {bus.cpu_hold, bus.cpu_nReset}, 2'b10);
            chk("bad_count_not_ready", 64'(bus.in_ready), 64'd0);
            chk("bad_count_no_done", 64'(done_cnt - d0), 64'd0);
            return;
        end
        model_push(d, n);
        if (noise) bus.start = 1'b1;
        for (int i = 0; i < n*B; i++)
            send_byte(d[i], maxgap);
        bus.start = 1'b0;
        exp_done = 1'b1;
`ifdef PM_LOADER_CHECKSUM_EN
        begin
            byte unsigned x;
            x = 8'h00;
            for (int i = 0; i < n*B; i++) x = x ^ d[i];
            if (cks_bad) begin
                x = x ^ 8'h01;
                exp_done = 1'b0;
            end
            send_byte(x, maxgap);
        end
`endif
        repeat (6) @(negedge clk);
        chk("done_pulses", 64'(done_cnt - d0), 64'(exp_done));
        chk("writes_drained", 64'(exp_q.size()), 64'd0);
        chk("err_after_load", 64'(bus.err), 64'(!exp_done));
        chk("core_state_after_load", {bus.cpu_hold, bus.cpu_nReset}, exp_done ? 2'b01 : 2'b10);
        chk("idle_not_ready", 64'(bus.in_ready), 64'd0);
    endtask

    task automatic rand_bytes(input int cnt, output byte unsigned d[$]);
        d = {};
        for (int i = 0; i < cnt; i++) d.push_back(8'($urandom));
    endtask

    initial begin
        byte unsigned d[$];
        int w0;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        #1 nReset = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_flags", {bus.in_ready, bus.wr_en, bus.cpu_hold, bus.cpu_nReset, bus.done, bus.err}, 6'b000100);
        chk("reset_wr_addr", 64'(bus.wr_addr), 64'd0);
        chk("reset_wr_data", 64'(bus.wr_data), 64'd0);
        nReset = 1'b1;
        @(negedge clk);

        d = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
        run_load(2, d, 0, 1'b0, 1'b0);

        d = {};
        run_load(0, d, 0, 1'b0, 1'b0);
        rand_bytes(B, d);
        run_load(1, d, 1, 1'b0, 1'b0);

        d = {};
        run_load(MAXN + 1, d, 0, 1'b0, 1'b0);
        rand_bytes(2*B, d);
        run_load(2, d, 0, 1'b0, 1'b0);

        rand_bytes(MAXN*B, d);
        run_load(MAXN, d, 3, 1'b0, 1'b0);

        rand_bytes(3*B, d);
        run_load(3, d, 1, 1'b1, 1'b0);

        for (int k = 0; k < 4; k++) begin
            int n;
            n = $urandom_range(1, 8);
            rand_bytes(n*B, d);
            run_load(n, d, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0);
        end

        // Abort mid-load: only instruction 0 may be written.
        rand_bytes(2*B, d);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        send_byte(8'd2, 0);
        model_push(d, 1);
        for (int i = 0; i < B + 2; i++) send_byte(d[i], 0);
        nReset = 1'b0;
        @(negedge clk);
        chk("abort_flags", {bus.in_ready, bus.wr_en, bus.cpu_hold, bus.cpu_nReset, bus.done, bus.err}, 6'b000100);
        chk("abort_wr_addr", 64'(bus.wr_addr), 64'd0);
        chk("abort_wr_data", 64'(bus.wr_data), 64'd0);
        chk("abort_first_write_seen", 64'(exp_q.size()), 64'd0);
        nReset = 1'b1;
        w0 = wr_cnt;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_data = 8'($urandom);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("no_write_after_abort", 64'(wr_cnt - w0), 64'd0);
        chk("idle_after_abort", {bus.in_ready, bus.cpu_hold, bus.cpu_nReset}, 3'b001);

`ifdef PM_LOADER_CHECKSUM_EN
        d = '{8'h12, 8'h34, 8'h56};
        run_load(1, d, 0, 1'b0, 1'b0);
        run_load(1, d, 0, 1'b0, 1'b1);
        rand_bytes(2*B, d);
        run_load(2, d, 0, 1'b0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
